// File: rtl/dev_bus_arbiter_pkg.sv
// dev_arb_pkg: shared types and constants for the Aquila device-bus arbiter.
//   arb_state_t      : arbiter FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   ARB_TIMEOUT_DATA : read data returned on a forced (timed-out) completion
//   idx_width()      : width of a requester index for a given requester count
package dev_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEADBEEF;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dev_bus_arbiter_if.sv
// dev_bus_arbiter_if: bundles the requester-side and device-side signals of
// the device-bus arbiter.
//   req_strobe/addr/rw/be/wdata : requester requests (packed per requester)
//   req_ready/req_rdata         : completion pulse and read data to requesters
//   dev_strobe/addr/rw/be/wdata : single granted request towards the device
//   dev_ready/dev_rdata         : device completion and read data
//   arb_timeout                 : forced-completion pulse
// Modports:
//   slave  : the arbiter's view
//   master : the surrounding system's view (requesters plus device)
interface dev_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);
    logic [NUM_REQ-1:0]          req_strobe;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr;
    logic [NUM_REQ-1:0]          req_rw;
    logic [NUM_REQ*DATA_W/8-1:0] req_be;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata;
    logic [NUM_REQ-1:0]          req_ready;
    logic [DATA_W-1:0]           req_rdata;

    logic                        dev_strobe;
    logic [ADDR_W-1:0]           dev_addr;
    logic                        dev_rw;
    logic [DATA_W/8-1:0]         dev_be;
    logic [DATA_W-1:0]           dev_wdata;
    logic                        dev_ready;
    logic [DATA_W-1:0]           dev_rdata;

    logic                        arb_timeout;

    modport slave (
        input  req_strobe, req_addr, req_rw, req_be, req_wdata,
        output req_ready, req_rdata,
        output dev_strobe, dev_addr, dev_rw, dev_be, dev_wdata,
        input  dev_ready, dev_rdata,
        output arb_timeout
    );

    modport master (
        output req_strobe, req_addr, req_rw, req_be, req_wdata,
        input  req_ready, req_rdata,
        input  dev_strobe, dev_addr, dev_rw, dev_be, dev_wdata,
        output dev_ready, dev_rdata,
        input  arb_timeout
    );

endinterface

// File: rtl/dev_bus_arbiter_rr_pick.sv
// dev_rr_pick: combinational rotate-priority picker.
//   pending : per-requester pending flags
//   rr_ptr  : index with highest priority this round
//   index   : first pending index at or after rr_ptr, wrapping
//   valid   : at least one requester is pending
module dev_rr_pick
    import dev_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    int unsigned cand;

    always_comb begin
        index = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!valid && pending[IDX_W'(cand)]) begin
                index = IDX_W'(cand);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dev_bus_arbiter.sv
// dev_bus_arbiter: shares one Aquila device-bus slave port among NUM_REQ
// requesters. Strobes are latched as pending, granted round-robin and run
// one transaction at a time (IDLE -> ISSUE -> WAIT -> RESP).
//   clk   : clock
//   rst_n : synchronous active-low reset (the device must share it)
//   bus   : dev_bus_arbiter_if.slave (requester and device signals)
// Optional feature macro DEV_ARB_TIMEOUT_EN: WAIT is abandoned after
// TIMEOUT_CYCLES cycles without dev_ready; the requester gets
// ARB_TIMEOUT_DATA and arb_timeout pulses in RESP. Without the macro WAIT
// waits forever and arb_timeout is tied low.
module dev_bus_arbiter
    import dev_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32
`ifdef DEV_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    dev_bus_arbiter_if.slave bus
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  pending_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [IDX_W-1:0]    mux_idx;
    logic [IDX_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0]  ready_vec;
    logic                timeout_hit;

    dev_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .index   (pick_idx),
        .valid   (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_valid) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.dev_ready || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_vec = '0;
        if (state_q == RESP) ready_vec[grant_q] = 1'b1;
    end

    // Outside a transaction the device-side mux shows requester 0.
    assign mux_idx        = (state_q == IDLE) ? '0 : grant_q;
    assign next_ptr       = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

    assign bus.req_ready  = ready_vec;
    assign bus.req_rdata  = (state_q == RESP) ? rdata_q : '0;
    assign bus.dev_strobe = (state_q == ISSUE);
    assign bus.dev_addr   = bus.req_addr[int'(mux_idx)*ADDR_W +: ADDR_W];
    assign bus.dev_rw     = bus.req_rw[mux_idx];
    assign bus.dev_be     = bus.req_be[int'(mux_idx)*BE_W +: BE_W];
    assign bus.dev_wdata  = bus.req_wdata[int'(mux_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            // A fresh strobe wins over the RESP clear of the same requester.
            pending_q <= (pending_q & ~ready_vec) | bus.req_strobe;
            if (state_q == IDLE && pick_valid) grant_q <= pick_idx;
            if (state_q == WAIT) begin
                if (bus.dev_ready)    rdata_q <= bus.dev_rdata;
                else if (timeout_hit) rdata_q <= DATA_W'(ARB_TIMEOUT_DATA);
            end
            if (state_q == RESP) rr_ptr_q <= next_ptr;
        end
    end

`ifdef DEV_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle, so RESP follows at WAIT+TIMEOUT_CYCLES.
    assign timeout_hit     = (state_q == WAIT) && !bus.dev_ready &&
                             (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.arb_timeout = (state_q == RESP) && timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == ISSUE) begin
                wait_cnt_q <= '0;
                timeout_q  <= 1'b0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                timeout_q  <= timeout_hit;
            end
        end
    end
`else
    assign timeout_hit     = 1'b0;
    assign bus.arb_timeout = 1'b0;
`endif

endmodule
